pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the 10-bit-address processor. It holds the architectural PC, issues single-word fetches to instruction memory with a req/ack handshake, and presents each fetched instruction to decode with a valid/ready handshake. On every accepted instruction it consumes the next-address logic's `next_pc` and `incr_pc` results, and optionally captures the return address into a link register. It is the consumer end of the next-address interface: its `pc` drives the next-address logic, and it loads that logic's result back.

---
 rtl/pc_fetch_unit.sv | 125 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Holds the architectural PC and runs the fetch/issue sequence. Each
// instruction is fetched with a req/ack handshake, held for decode with a
// valid/ready handshake, and retired when decode accepts it. On retirement,
// the PC is loaded with the next-address logic's result, and the return
// address may be captured into the link register.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pc                  current PC, drives the next-address logic
//   next_pc, incr_pc    next-address logic results (incr_pc low PC_W bits used)
//   imem_req/addr       fetch request and address (combinational from state)
//   imem_ack/rdata      fetch completion and returned word
//   instr/instr_valid   instruction held for decode
//   instr_ready         decode accepts instr
//   link_we, link_reg   capture return address on acceptance / captured value
//   halt, halted        park on acceptance / unit parked
//   retired             count of accepted instructions (wraps at 16 bits)
module pc_fetch_unit #(
  parameter int              PC_W     = 10,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    next_pc,
  input  logic [31:0]        incr_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               link_we,
  output logic [PC_W-1:0]    link_reg,
  input  logic               halt,
  output logic               halted,
  output logic [15:0]        retired
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [PC_W-1:0]      link_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 valid_q;
  logic                 halted_q;
  logic [15:0]          retired_q;
  logic [15:0]          retired_d;
  logic                 accept;

  // Only the low PC_W bits of the incremented PC are architecturally meaningful.
  logic                 unused_incr_hi;
  assign unused_incr_hi = ^incr_pc[31:PC_W];

  assign accept    = (state_q == ISSUE) && valid_q && instr_ready;
  assign retired_d = retired_q + 16'd1;

  // The request is gated by rst_n so that it is low throughout reset, even
  // though the reset state is FETCH.
  assign imem_req    = rst_n && (state_q == FETCH);
  assign imem_addr   = pc_q;

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign link_reg    = link_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      link_q    <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            // next_pc is loaded verbatim; any wrap comes from the
            // next-address logic.
            pc_q      <= next_pc;
            valid_q   <= 1'b0;
            retired_q <= retired_d;
            if (link_we) begin
              link_q <= incr_pc[PC_W-1:0];
            end
            if (halt) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q  <= FETCH;
            end
          end
        end
        HALT: begin
          // Parked until reset.
          state_q <= HALT;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pc;
  logic [9:0]  next_pc = '0;
  logic [31:0] incr_pc = '0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        link_we = 1'b0;
  logic [9:0]  link_reg;
  logic        halt = 1'b0;
  logic        halted;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  // Behavioural reference: what decode should be seeing right now.
  logic [9:0]  m_pc     = '0;
  logic [31:0] m_instr  = '0;
  logic [9:0]  m_link   = '0;
  logic [15:0] m_ret    = '0;
  bit          m_have   = 1'b0;   // an instruction is waiting for decode
  bit          m_parked = 1'b0;   // a halting instruction has retired
  bit          chk_en   = 1'b0;
  bit          auto_np  = 1'b0;

  pc_fetch_unit #(.PC_W(10), .INSTR_W(32), .RESET_PC(10'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .next_pc     (next_pc),
    .incr_pc     (incr_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .link_we     (link_we),
    .link_reg    (link_reg),
    .halt        (halt),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model, updated on the same edges as the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = '0; m_instr = '0; m_link = '0; m_ret = '0;
      m_have = 1'b0; m_parked = 1'b0;
      chk_en = 1'b1;
    end else if (m_parked) begin
      // nothing moves once parked
    end else if (!m_have) begin
      if (imem_ack) begin
        m_instr = imem_rdata;
        m_have  = 1'b1;
      end
    end else if (instr_ready) begin
      m_pc   = next_pc;
      m_have = 1'b0;
      m_ret  = m_ret + 16'd1;
      if (link_we) m_link = incr_pc[9:0];
      if (halt) m_parked = 1'b1;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("imem_req", 32'(imem_req), 32'(rst_n && !m_have && !m_parked));
      if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("instr", instr, m_instr);
      chk("instr_valid", 32'(instr_valid), 32'(m_have));
      chk("link_reg", 32'(link_reg), 32'(m_link));
      chk("halted", 32'(halted), 32'(m_parked));
      chk("retired", 32'(retired), 32'(m_ret));
    end
  end

  // One clock: inputs already set; returns at the following falling edge.
  task automatic cyc();
    if (auto_np) begin
      next_pc = m_pc + 10'd1;
      incr_pc = 32'(m_pc) + 32'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    #3 rst_n = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // ---- reset, straight-line fetch at two cycles per instruction
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1; instr_ready = 1'b1; auto_np = 1'b1;
    for (int k = 0; k < 8; k++) begin
      imem_rdata = 32'h1000 + 32'(k);
      chk("seq_req", 32'(imem_req), 32'((k % 2) == 0));
      if ((k % 2) == 0) chk("seq_addr", 32'(imem_addr), 32'(k / 2));
      cyc();
    end
    chk("seq_retired4", 32'(retired), 32'd4);

    // ---- ack delay at pc 5
    cyc(); cyc();
    chk("pc5", 32'(pc), 32'd5);
    imem_ack = 1'b0; instr_ready = 1'b0; imem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'd5);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      imem_ack = (i == 3);
      cyc();
    end
    imem_ack = 1'b0;
    chk("ack_instr", instr, 32'hDEADBEEF);
    chk("ack_valid", 32'(instr_valid), 32'd1);

    // ---- ready delay
    imem_rdata = 32'h0BAD0BAD;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall_instr", instr, 32'hDEADBEEF);
      chk("stall_pc", 32'(pc), 32'd5);
      chk("stall_ret", 32'(retired), 32'd5);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    auto_np = 1'b0; next_pc = 10'h012; incr_pc = 32'd6; instr_ready = 1'b1;
    cyc();
    chk("acc_pc", 32'(pc), 32'h012);
    chk("acc_ret", 32'(retired), 32'd6);
    chk("acc_valid", 32'(instr_valid), 32'd0);

    // ---- branch with link
    imem_ack = 1'b1; cyc();
    imem_ack = 1'b0; next_pc = 10'h200; incr_pc = 32'h13; link_we = 1'b1;
    cyc();
    link_we = 1'b0;
    chk("br_addr", 32'(imem_addr), 32'h200);
    chk("br_req", 32'(imem_req), 32'd1);
    chk("br_link", 32'(link_reg), 32'h013);

    // ---- wrap 1023 -> 0, then halt
    imem_ack = 1'b1; cyc();
    next_pc = 10'h3FF; incr_pc = 32'h201; cyc();
    chk("pc1023", 32'(pc), 32'h3FF);
    cyc();
    next_pc = 10'h000; incr_pc = 32'h400; cyc();
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    chk("wrap_req", 32'(imem_req), 32'd1);
    cyc();
    next_pc = 10'h001; halt = 1'b1; cyc();
    halt = 1'b0;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_ret", 32'(retired), 32'd10);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("park_req", 32'(imem_req), 32'd0);
      chk("park_ret", 32'(retired), 32'd10);
    end
    chk("park_pc", 32'(pc), 32'd1);

    // ---- asynchronous reset while in ISSUE
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_exit_halt", 32'(halted), 32'd0);
    imem_ack = 1'b1; instr_ready = 1'b1; link_we = 1'b1;
    incr_pc = 32'h77; next_pc = 10'd3;
    #3 rst_n = 1'b1;
    @(negedge clk);
    cyc();
    link_we = 1'b0; instr_ready = 1'b0;
    cyc();
    chk("pre_valid", 32'(instr_valid), 32'd1);
    chk("pre_link", 32'(link_reg), 32'h077);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_link", 32'(link_reg), 32'd0);
    chk("async_ret", 32'(retired), 32'd0);
    imem_ack = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", 32'(imem_addr), 32'd0);

    // ---- randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      imem_ack    = ($urandom_range(9) < 6);
      instr_ready = ($urandom_range(9) < 6);
      imem_rdata  = $urandom;
      link_we     = ($urandom_range(3) == 0);
      halt        = ($urandom_range(29) == 0);
      if ($urandom_range(1) == 0) next_pc = 10'($urandom);
      else                        next_pc = m_pc + 10'd1;
      incr_pc = {$urandom_range(4194303), 10'd0} | 32'(10'(m_pc + 10'd1));
      if ((m_parked && $urandom_range(3) == 0) || $urandom_range(199) == 0) begin
        reset_pulse();
      end else begin
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
